// File: rtl/sipo_deser.sv
// Serial-in, parallel-out deserializer: assembles N qualified serial bits into a word
// and hands it to a single-entry output stage with valid/ready and a sticky overrun flag.
module sipo_deser #(
  parameter int N         = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic         CLK,
  input  logic         res,
  input  logic         din,
  input  logic         bit_en,
  input  logic         start,
  input  logic         ready,
  input  logic         clr_ovr,
  output logic [N-1:0] dout,
  output logic         valid,
  output logic         busy,
  output logic         overrun
);

  // Output handshake: a word transfers on every edge where valid=1 and ready=1;
  // valid never drops without ready, and dout is stable while valid=1 and ready=0.

  localparam int CW = $clog2(N + 1);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  sr_q, sr_d;
  logic [N-1:0]  dout_q, dout_d;
  logic          valid_q, valid_d;
  logic          ovr_q, ovr_d;
  logic [N-1:0]  shift_src;
  logic [N-1:0]  shifted;
  logic          done;
  logic          load;

  // A start edge shifts into a cleared register so its own bit becomes frame bit 0.
  always_comb begin
    shift_src = start ? '0 : sr_q;
    if (MSB_FIRST) shifted = {shift_src[N-2:0], din};
    else           shifted = {din, shift_src[N-1:1]};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    done    = 1'b0;
    if (start) begin
      state_d = SHIFT;
      cnt_d   = bit_en ? CW'(1) : '0;
      sr_d    = bit_en ? shifted : '0;
    end else if (state_q == SHIFT && bit_en) begin
      sr_d = shifted;
      if (cnt_q == CW'(N - 1)) begin
        done    = 1'b1;
        state_d = IDLE;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // Completed word is taken when the slot is empty or being drained this edge.
  always_comb begin
    load    = done & (~valid_q | ready);
    valid_d = valid_q;
    dout_d  = dout_q;
    if (load) begin
      valid_d = 1'b1;
      dout_d  = shifted;
    end else if (valid_q & ready) begin
      valid_d = 1'b0;
    end
    ovr_d = ovr_q;
    if (clr_ovr)      ovr_d = 1'b0;
    if (done & ~load) ovr_d = 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (res) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sr_q    <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign dout    = dout_q;
  assign valid   = valid_q;
  assign busy    = (state_q == SHIFT);
  assign overrun = ovr_q;

endmodule

// File: tb/tb_sipo_deser.sv
// Bench for sipo_deser: directed frames plus random traffic, compared against a
// bit-list reference model for both bit orders.
module tb_sipo_deser;

  localparam int N = 8;

  logic         CLK = 1'b0;
  logic         res = 1'b1, din = 1'b0, bit_en = 1'b0, start = 1'b0, ready = 1'b0, clr_ovr = 1'b0;
  logic [N-1:0] dout, dout_l;
  logic         valid, busy, overrun;
  logic         valid_l, busy_l, overrun_l;

  always #5 CLK = ~CLK;

  sipo_deser #(.N(N), .MSB_FIRST(1'b1)) dut (
    .CLK(CLK), .res(res), .din(din), .bit_en(bit_en), .start(start), .ready(ready),
    .clr_ovr(clr_ovr), .dout(dout), .valid(valid), .busy(busy), .overrun(overrun)
  );

  sipo_deser #(.N(N), .MSB_FIRST(1'b0)) dut_l (
    .CLK(CLK), .res(res), .din(din), .bit_en(bit_en), .start(start), .ready(ready),
    .clr_ovr(clr_ovr), .dout(dout_l), .valid(valid_l), .busy(busy_l), .overrun(overrun_l)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 'h%0h expected 'h%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: frame is a list of received bits; output stage is one slot.
  bit           m_bits[$];
  bit           m_busy  = 1'b0;
  bit           m_valid = 1'b0;
  bit           m_ovr   = 1'b0;
  logic [N-1:0] m_dout   = '0;
  logic [N-1:0] m_dout_l = '0;
  logic [N-1:0] exp_q[$];

  function automatic logic [N-1:0] assemble(input bit msb);
    logic [N-1:0] w;
    w = '0;
    for (int i = 0; i < N; i++) begin
      if (msb) w[N-1-i] = m_bits[i];
      else     w[i]     = m_bits[i];
    end
    return w;
  endfunction

  task automatic step(input logic d, input logic be, input logic st, input logic rd,
                      input logic co, input logic rs);
    logic [N-1:0] pre_dout, w, wl;
    bit done, consume;
    @(negedge CLK);
    din = d; bit_en = be; start = st; ready = rd; clr_ovr = co; res = rs;
    #1;
    pre_dout = dout;
    @(posedge CLK);
    if (rs) begin
      m_bits.delete();
      m_busy = 0; m_valid = 0; m_ovr = 0; m_dout = '0; m_dout_l = '0;
      exp_q.delete();
    end else begin
      done = 0; w = '0; wl = '0;
      consume = m_valid && rd;
      if (consume) begin
        check_eq("scoreboard_depth", exp_q.size(), 1);
        if (exp_q.size() != 0) check_eq("consumed_word", pre_dout, exp_q.pop_front());
      end
      if (st) begin
        m_bits.delete();
        m_busy = 1;
        if (be) m_bits.push_back(d);
      end else if (m_busy && be) begin
        m_bits.push_back(d);
        if (m_bits.size() == N) begin
          done = 1; w = assemble(1); wl = assemble(0);
          m_bits.delete();
          m_busy = 0;
        end
      end
      if (co) m_ovr = 0;
      if (done) begin
        if (!m_valid || rd) begin
          m_dout = w; m_dout_l = wl; m_valid = 1;
          exp_q.push_back(w);
        end else begin
          m_ovr = 1;
        end
      end else if (consume) begin
        m_valid = 0;
      end
    end
    #1;
    check_eq("dout", dout, m_dout);
    check_eq("valid", valid, m_valid);
    check_eq("busy", busy, m_busy);
    check_eq("overrun", overrun, m_ovr);
    check_eq("dout_lsb", dout_l, m_dout_l);
    check_eq("valid_lsb", valid_l, m_valid);
    check_eq("busy_lsb", busy_l, m_busy);
    check_eq("overrun_lsb", overrun_l, m_ovr);
  endtask

  // Start cycle, then N bits MSB-first; rd_last applies on the final bit edge.
  task automatic send_word(input logic [N-1:0] w, input bit gap, input logic rd, input logic rd_last);
    step(1'b0, 1'b0, 1'b1, rd, 1'b0, 1'b0);
    for (int i = N - 1; i >= 0; i--) begin
      if (gap) step(1'b0, 1'b0, 1'b0, rd, 1'b0, 1'b0);
      step(w[i], 1'b1, 1'b0, (i == 0) ? rd_last : rd, 1'b0, 1'b0);
    end
  endtask

  task automatic idle(input logic rd);
    step(1'b0, 1'b0, 1'b0, rd, 1'b0, 1'b0);
  endtask

  initial begin
    // reset
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check_eq("reset_dout", dout, 0);
    check_eq("reset_valid", valid, 0);
    check_eq("reset_overrun", overrun, 0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("idle_ignores_bit_en", busy, 0);

    // basic frame
    send_word(8'hB2, 1'b0, 1'b1, 1'b1);
    check_eq("basic_dout", dout, 8'hB2);
    check_eq("basic_dout_lsb", dout_l, 8'h4D);
    check_eq("basic_valid", valid, 1);
    check_eq("basic_busy", busy, 0);
    idle(1'b1);
    check_eq("basic_valid_one_cycle", valid, 0);

    // gapped input
    send_word(8'hB2, 1'b1, 1'b1, 1'b1);
    check_eq("gap_dout", dout, 8'hB2);
    idle(1'b1);

    // backpressure and overrun
    send_word(8'hA5, 1'b0, 1'b0, 1'b0);
    send_word(8'h3C, 1'b0, 1'b0, 1'b0);
    check_eq("bp_dout", dout, 8'hA5);
    check_eq("bp_valid", valid, 1);
    check_eq("bp_overrun", overrun, 1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check_eq("clr_overrun", overrun, 0);
    check_eq("clr_dout", dout, 8'hA5);
    idle(1'b1);

    // simultaneous consume and reload
    send_word(8'h0F, 1'b0, 1'b0, 1'b0);
    send_word(8'h5A, 1'b0, 1'b0, 1'b1);
    check_eq("reload_dout", dout, 8'h5A);
    check_eq("reload_valid", valid, 1);
    check_eq("reload_overrun", overrun, 0);
    idle(1'b1);

    // restart mid-frame
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    send_word(8'h5A, 1'b0, 1'b1, 1'b1);
    check_eq("restart_dout", dout, 8'h5A);
    check_eq("restart_overrun", overrun, 0);
    idle(1'b0);

    // reset mid-frame
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    check_eq("rst_dout", dout, 0);
    check_eq("rst_valid", valid, 0);
    check_eq("rst_busy", busy, 0);
    send_word(8'hFF, 1'b0, 1'b1, 1'b1);
    check_eq("post_rst_dout", dout, 8'hFF);
    check_eq("post_rst_valid", valid, 1);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      step(1'($urandom_range(0, 1)),
           1'($urandom_range(0, 99) < 60),
           1'($urandom_range(0, 99) < 4),
           1'($urandom_range(0, 99) < 40),
           1'($urandom_range(0, 99) < 8),
           1'($urandom_range(0, 999) < 5));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
